// File: rtl/decode_stage_fwd_if.sv
// Decode-stage bus bundle.
// Groups every decode-stage signal except clk/reset:
//   F/D inputs     : F_PC, D_PC, D_instr
//   hazard control : stall, flush
//   forwarding     : E_fwd_*, M_fwd_* (en/addr/data)
//   writeback      : W_RegWrite, W_RegToWrite, W_WriteData
//   PC outputs     : next_pc, redirect, flush_fd
//   ID/EX outputs  : E_PC, E_instr, E_RsData, E_RtData, E_EXTData, E_WriteAddr
// The slave modport is the decode stage; the master modport drives it.
interface decode_stage_fwd_if #(
    parameter int unsigned REG_ADDR_W = 5
) ();
    logic [31:0]           F_PC;
    logic [31:0]           D_PC;
    logic [31:0]           D_instr;
    logic                  stall;
    logic                  flush;
    logic                  E_fwd_en;
    logic [REG_ADDR_W-1:0] E_fwd_addr;
    logic [31:0]           E_fwd_data;
    logic                  M_fwd_en;
    logic [REG_ADDR_W-1:0] M_fwd_addr;
    logic [31:0]           M_fwd_data;
    logic                  W_RegWrite;
    logic [REG_ADDR_W-1:0] W_RegToWrite;
    logic [31:0]           W_WriteData;
    logic [31:0]           next_pc;
    logic                  redirect;
    logic                  flush_fd;
    logic [31:0]           E_PC;
    logic [31:0]           E_instr;
    logic [31:0]           E_RsData;
    logic [31:0]           E_RtData;
    logic [31:0]           E_EXTData;
    logic [REG_ADDR_W-1:0] E_WriteAddr;

    modport slave (
        input  F_PC, D_PC, D_instr, stall, flush,
        input  E_fwd_en, E_fwd_addr, E_fwd_data,
        input  M_fwd_en, M_fwd_addr, M_fwd_data,
        input  W_RegWrite, W_RegToWrite, W_WriteData,
        output next_pc, redirect, flush_fd,
        output E_PC, E_instr, E_RsData, E_RtData, E_EXTData, E_WriteAddr
    );

    modport master (
        output F_PC, D_PC, D_instr, stall, flush,
        output E_fwd_en, E_fwd_addr, E_fwd_data,
        output M_fwd_en, M_fwd_addr, M_fwd_data,
        output W_RegWrite, W_RegToWrite, W_WriteData,
        input  next_pc, redirect, flush_fd,
        input  E_PC, E_instr, E_RsData, E_RtData, E_EXTData, E_WriteAddr
    );
endinterface

// File: rtl/decode_stage_fwd.sv
// MIPS decode stage with operand forwarding and the ID/EX pipeline register.
// Holds the register file, immediate extender, branch comparator and next-PC
// logic. Ports:
//   clk, reset : clock and synchronous active-high reset
//   bus        : decode_stage_fwd_if.slave carrying F/D inputs, hazard control,
//                E/M forwarding, W writeback, next-PC outputs and ID/EX outputs
// DELAY_SLOT=0 makes every taken control transfer also squash IF/ID.
module decode_stage_fwd #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter logic [31:0] PC_RESET   = 32'h0000_3000,
    parameter bit          DELAY_SLOT = 1'b1
) (
    input logic               clk,
    input logic               reset,
    decode_stage_fwd_if.slave bus
);
    localparam int unsigned NumRegs = 2 ** REG_ADDR_W;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpJal   = 6'h03;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpBlez  = 6'h06;
    localparam logic [5:0] OpBgtz  = 6'h07;
    localparam logic [5:0] OpAndi  = 6'h0c;
    localparam logic [5:0] OpOri   = 6'h0d;
    localparam logic [5:0] OpXori  = 6'h0e;
    localparam logic [5:0] OpLui   = 6'h0f;
    localparam logic [5:0] FnJr    = 6'h08;
    localparam logic [5:0] FnJalr  = 6'h09;

    // Instruction fields
    logic [5:0]            opcode;
    logic [5:0]            funct;
    logic [REG_ADDR_W-1:0] rs_addr;
    logic [REG_ADDR_W-1:0] rt_addr;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic [15:0]           imm16;
    logic [25:0]           imm26;

    assign opcode  = bus.D_instr[31:26];
    assign funct   = bus.D_instr[5:0];
    assign rs_addr = REG_ADDR_W'(bus.D_instr[25:21]);
    assign rt_addr = REG_ADDR_W'(bus.D_instr[20:16]);
    assign rd_addr = REG_ADDR_W'(bus.D_instr[15:11]);
    assign imm16   = bus.D_instr[15:0];
    assign imm26   = bus.D_instr[25:0];

    logic is_jr;
    logic is_jalr;
    assign is_jr   = (opcode == OpRtype) && (funct == FnJr);
    assign is_jalr = (opcode == OpRtype) && (funct == FnJalr);

    // Register file
    logic [31:0] rf_q [NumRegs];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NumRegs; i++) begin
                rf_q[i] <= '0;
            end
        end else if (bus.W_RegWrite && (bus.W_RegToWrite != '0)) begin
            rf_q[bus.W_RegToWrite] <= bus.W_WriteData;
        end
    end

    // Operand source priority: E forward, M forward, W bypass, array.
    // Address 0 short-circuits everything, so zero-addressed forwards are ignored.
    function automatic logic [31:0] read_op(input logic [REG_ADDR_W-1:0] addr,
                                            input logic [31:0]           array_val);
        if (addr == '0) begin
            return 32'h0;
        end else if (bus.E_fwd_en && (bus.E_fwd_addr == addr)) begin
            return bus.E_fwd_data;
        end else if (bus.M_fwd_en && (bus.M_fwd_addr == addr)) begin
            return bus.M_fwd_data;
        end else if (bus.W_RegWrite && (bus.W_RegToWrite == addr)) begin
            return bus.W_WriteData;
        end else begin
            return array_val;
        end
    endfunction

    logic [31:0] rs_val;
    logic [31:0] rt_val;
    assign rs_val = read_op(rs_addr, rf_q[rs_addr]);
    assign rt_val = read_op(rt_addr, rf_q[rt_addr]);

    // Immediate extender
    logic [31:0] ext_val;

    always_comb begin
        ext_val = {{16{imm16[15]}}, imm16};
        case (opcode)
            OpAndi, OpOri, OpXori: ext_val = {16'h0, imm16};
            OpLui:                 ext_val = {imm16, 16'h0};
            default:               ext_val = {{16{imm16[15]}}, imm16};
        endcase
    end

    // Destination register
    logic [REG_ADDR_W-1:0] dest_addr;

    always_comb begin
        dest_addr = '0;
        case (opcode)
            OpRtype: dest_addr = is_jr ? '0 : rd_addr;
            OpJal:   dest_addr = REG_ADDR_W'(5'd31);
            // addi..lui, then the loads
            6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f,
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: dest_addr = rt_addr;
            default: dest_addr = '0;
        endcase
    end

    // Next PC
    logic [31:0] seq_pc;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] ctrl_target;
    logic        ctrl_take;

    assign seq_pc        = bus.F_PC + 32'd4;
    assign branch_target = bus.D_PC + 32'd4 + {{14{imm16[15]}}, imm16, 2'b00};
    assign jump_target   = {bus.D_PC[31:28], imm26, 2'b00};

    always_comb begin
        ctrl_take   = 1'b0;
        ctrl_target = branch_target;
        case (opcode)
            OpBeq:  ctrl_take = (rs_val == rt_val);
            OpBne:  ctrl_take = (rs_val != rt_val);
            OpBlez: ctrl_take = ($signed(rs_val) <= 32'sd0);
            OpBgtz: ctrl_take = ($signed(rs_val) > 32'sd0);
            OpJ, OpJal: begin
                ctrl_take   = 1'b1;
                ctrl_target = jump_target;
            end
            OpRtype: begin
                ctrl_take   = is_jr || is_jalr;
                ctrl_target = rs_val;
            end
            default: ctrl_take = 1'b0;
        endcase
    end

    // A stalled D instruction must not steer fetch until it actually issues.
    assign bus.redirect = ctrl_take && !bus.stall;
    assign bus.next_pc  = bus.redirect ? ctrl_target : seq_pc;
    assign bus.flush_fd = DELAY_SLOT ? 1'b0 : bus.redirect;

    // ID/EX register; all-zero is the sll $0 bubble
    logic [31:0]           e_pc_q;
    logic [31:0]           e_instr_q;
    logic [31:0]           e_rs_q;
    logic [31:0]           e_rt_q;
    logic [31:0]           e_ext_q;
    logic [REG_ADDR_W-1:0] e_waddr_q;

    always_ff @(posedge clk) begin
        if (reset || bus.stall || bus.flush) begin
            e_pc_q    <= '0;
            e_instr_q <= '0;
            e_rs_q    <= '0;
            e_rt_q    <= '0;
            e_ext_q   <= '0;
            e_waddr_q <= '0;
        end else begin
            e_pc_q    <= bus.D_PC;
            e_instr_q <= bus.D_instr;
            e_rs_q    <= rs_val;
            e_rt_q    <= rt_val;
            e_ext_q   <= ext_val;
            e_waddr_q <= dest_addr;
        end
    end

    assign bus.E_PC        = e_pc_q;
    assign bus.E_instr     = e_instr_q;
    assign bus.E_RsData    = e_rs_q;
    assign bus.E_RtData    = e_rt_q;
    assign bus.E_EXTData   = e_ext_q;
    assign bus.E_WriteAddr = e_waddr_q;

    // Fetch PCs stay on the same word alignment as the reset PC.
    assert property (@(posedge clk) disable iff (reset) (bus.F_PC[1:0] == PC_RESET[1:0]));

endmodule
